fpu_issue_ctrl: RTL and testbench

- Issue controller for the FPU cluster: i2f, fadd, fmul (fixed latency) and fdiv (variable latency).
- Accepts one FPU op per cycle from the CPU and pulses the start of the selected unit.
- Stalls the CPU on register hazards, on result-bus slot conflicts and on a busy divider.
- All units share one result bus into the normaliser/writeback. This block owns the bus-slot reservation and the pending-register scoreboard.

---
 rtl/fpu_issue_ctrl.sv | 106 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: hazard/slot stalls, result-bus reservation and
// pending-register scoreboard for the i2f/fadd/fmul/fdiv cluster.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_I2F = 2,
    parameter int unsigned LAT_ADD = 4,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned MAXLAT  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_dest,
    input  logic [4:0]  req_src_a,
    input  logic        req_src_a_en,
    input  logic [4:0]  req_src_b,
    input  logic        req_src_b_en,
    output logic        req_stall,
    output logic        start_i2f,
    output logic        start_add,
    output logic        start_mul,
    output logic        start_div,
    output logic [4:0]  issue_dest,
    input  logic        div_req,
    output logic        div_grant,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    output logic [31:0] pending,
    output logic        fpu_busy
);

    localparam logic [1:0] OP_I2F = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [MAXLAT-1:0] resv, resv_next;
    logic [31:0]       pending_next;
    logic              div_busy, div_busy_next;
    logic [1:0]        div_wait, div_wait_next;
    logic              op_fixed, slot_taken, reg_hazard, accept;

    // Stall decision and combinational issue outputs
    always_comb begin
        op_fixed   = (req_op != OP_DIV);
        slot_taken = 1'b0;
        case (req_op)
            OP_I2F:  slot_taken = resv[LAT_I2F];
            OP_ADD:  slot_taken = resv[LAT_ADD];
            OP_MUL:  slot_taken = resv[LAT_MUL];
            default: slot_taken = 1'b0;
        endcase
        reg_hazard = (req_src_a_en & pending[req_src_a])
                   | (req_src_b_en & pending[req_src_b])
                   | pending[req_dest];
        req_stall  = reset | reg_hazard
                   | (op_fixed & slot_taken)
                   | ((req_op == OP_DIV) & div_busy)
                   | (op_fixed & div_wait[1]);
        accept     = req_valid & ~req_stall;
        start_i2f  = accept & (req_op == OP_I2F);
        start_add  = accept & (req_op == OP_ADD);
        start_mul  = accept & (req_op == OP_MUL);
        start_div  = accept & (req_op == OP_DIV);
        issue_dest = req_dest;
        div_grant  = div_req & ~resv[0] & ~reset;
    end

    // Next-state for reservations, scoreboard and divider tracking
    always_comb begin
        resv_next = {1'b0, resv[MAXLAT-1:1]};
        if (start_i2f) resv_next[LAT_I2F-1] = 1'b1;
        if (start_add) resv_next[LAT_ADD-1] = 1'b1;
        if (start_mul) resv_next[LAT_MUL-1] = 1'b1;

        // Clear before set so an issue wins over a same-register retire
        pending_next = pending;
        if (wb_valid) pending_next[wb_dest] = 1'b0;
        if (accept)   pending_next[req_dest] = 1'b1;

        div_busy_next = div_busy;
        if (start_div)      div_busy_next = 1'b1;
        else if (div_grant) div_busy_next = 1'b0;

        div_wait_next = div_wait;
        if (~div_req | div_grant)  div_wait_next = 2'd0;
        else if (div_wait != 2'd3) div_wait_next = div_wait + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resv     <= '0;
            pending  <= '0;
            div_busy <= 1'b0;
            div_wait <= 2'd0;
        end else begin
            resv     <= resv_next;
            pending  <= pending_next;
            div_busy <= div_busy_next;
            div_wait <= div_wait_next;
        end
    end

    assign fpu_busy = (|pending) | div_busy;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl with a cycle-indexed behavioural model
// of bus bookings, scoreboard and divider handshake.
module tb_fpu_issue_ctrl;

    localparam int unsigned MAXLAT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [4:0]  req_dest, req_src_a, req_src_b;
    logic        req_src_a_en, req_src_b_en;
    logic        req_stall, start_i2f, start_add, start_mul, start_div;
    logic [4:0]  issue_dest;
    logic        div_req, div_grant;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] pending;
    logic        fpu_busy;

    fpu_issue_ctrl #(.LAT_I2F(2), .LAT_ADD(4), .LAT_MUL(3), .MAXLAT(MAXLAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_dest(req_dest),
        .req_src_a(req_src_a), .req_src_a_en(req_src_a_en),
        .req_src_b(req_src_b), .req_src_b_en(req_src_b_en),
        .req_stall(req_stall),
        .start_i2f(start_i2f), .start_add(start_add),
        .start_mul(start_mul), .start_div(start_div),
        .issue_dest(issue_dest),
        .div_req(div_req), .div_grant(div_grant),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .pending(pending), .fpu_busy(fpu_busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: absolute-cycle bus bookings, pending set, divider state
    longint    cyc = 0;
    bit        booked[longint];
    bit [31:0] m_pend = '0;
    bit        m_dbusy = 1'b0;
    int        m_unGranted = 0;

    // Environment: scheduled writebacks and a simple divider
    logic [4:0] wb_at[longint];
    bit         d_active = 1'b0;
    int         d_cnt = 0;
    logic [4:0] d_dest = '0;
    int         div_delay = 3;

    bit fixed, e_stall, e_grant, acc;
    int lat;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'd0:    return 2;
            2'd1:    return 4;
            2'd2:    return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model
    always @(negedge clock) begin
        fixed = (req_op != 2'd3);
        lat   = lat_of(req_op);
        if (reset) begin
            e_stall = 1'b1;
            e_grant = 1'b0;
        end else begin
            e_stall = (req_src_a_en && m_pend[req_src_a]) ||
                      (req_src_b_en && m_pend[req_src_b]) ||
                      m_pend[req_dest] ||
                      (fixed && booked.exists(cyc + longint'(lat))) ||
                      (!fixed && m_dbusy) ||
                      (fixed && m_unGranted >= 2);
            e_grant = div_req && !booked.exists(cyc);
        end
        acc = req_valid && !e_stall;

        check("req_stall", 32'(req_stall), 32'(e_stall));
        check("start_i2f", 32'(start_i2f), 32'(acc && req_op == 2'd0));
        check("start_add", 32'(start_add), 32'(acc && req_op == 2'd1));
        check("start_mul", 32'(start_mul), 32'(acc && req_op == 2'd2));
        check("start_div", 32'(start_div), 32'(acc && req_op == 2'd3));
        check("issue_dest", 32'(issue_dest), 32'(req_dest));
        check("div_grant", 32'(div_grant), 32'(e_grant));
        check("pending", pending, m_pend);
        check("fpu_busy", 32'(fpu_busy), 32'((m_pend != 0) || m_dbusy));

        if (reset) begin
            m_pend = '0;
            m_dbusy = 1'b0;
            m_unGranted = 0;
            booked.delete();
            wb_at.delete();
            d_active = 1'b0;
        end else begin
            if (wb_valid) m_pend[wb_dest] = 1'b0;
            if (acc) m_pend[req_dest] = 1'b1;
            if (e_grant) begin
                m_dbusy = 1'b0;
                d_active = 1'b0;
                wb_at[cyc + 1] = d_dest;
            end
            if (acc && fixed) begin
                booked[cyc + longint'(lat)] = 1'b1;
                wb_at[cyc + longint'(lat) + 1] = req_dest;
            end
            if (acc && !fixed) begin
                m_dbusy = 1'b1;
                d_active = 1'b1;
                d_cnt = div_delay;
                d_dest = req_dest;
            end
            m_unGranted = (div_req && !e_grant) ? m_unGranted + 1 : 0;
            if (d_active && d_cnt > 0) d_cnt--;
        end
        if (booked.exists(cyc)) booked.delete(cyc);
        cyc++;
    end

    // Advance one cycle and drive environment-owned inputs
    task automatic next_cycle();
        int r;
        @(posedge clock);
        #1;
        wb_valid = 1'b0;
        wb_dest  = 5'd0;
        if (wb_at.exists(cyc)) begin
            wb_valid = 1'b1;
            wb_dest  = wb_at[cyc];
            wb_at.delete(cyc);
        end else if ($urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 31));
            if (!m_pend[r]) begin
                wb_valid = 1'b1;
                wb_dest  = 5'(r);
            end
        end
        div_req = d_active && (d_cnt == 0);
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [4:0] d,
                           input logic [4:0] a, input logic aen,
                           input logic [4:0] b, input logic ben);
        req_valid = v; req_op = op; req_dest = d;
        req_src_a = a; req_src_a_en = aen;
        req_src_b = b; req_src_b_en = ben;
    endtask

    task automatic rand_req();
        logic [1:0] op;
        int hi;
        op = 2'($urandom_range(0, 3));
        hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
        set_req($urandom_range(0, 9) < 8, op, 5'($urandom_range(0, hi)),
                5'($urandom_range(0, hi)), (op != 2'd0) && $urandom_range(0, 1) == 1,
                5'($urandom_range(0, hi)), $urandom_range(0, 1) == 1);
    endtask

    initial begin
        bit got_div;
        reset = 1'b1;
        wb_valid = 1'b0; wb_dest = '0; div_req = 1'b0;
        set_req(1'b1, 2'd1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        div_delay = 20;
        next_cycle();
        next_cycle();
        #1;
        check("lit_reset_stall", 32'(req_stall), 32'd1);
        check("lit_reset_pending", pending, 32'h0);

        next_cycle();
        reset = 1'b0;
        set_req(1'b1, 2'd1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1);
        #1;
        check("lit_fadd_start", 32'(start_add), 32'd1);
        check("lit_fadd_dest", 32'(issue_dest), 32'd5);

        next_cycle();
        set_req(1'b1, 2'd3, 5'd9, 5'd10, 1'b1, 5'd11, 1'b1);
        #1;
        check("lit_pending_20", pending, 32'h20);
        check("lit_fdiv_start", 32'(start_div), 32'd1);

        next_cycle();
        set_req(1'b1, 2'd3, 5'd12, 5'd13, 1'b1, 5'd14, 1'b1);
        #1;
        check("lit_pending_220", pending, 32'h220);
        check("lit_div_busy_stall", 32'(req_stall), 32'd1);
        check("lit_busy", 32'(fpu_busy), 32'd1);

        next_cycle();
        reset = 1'b1;
        #1;
        check("lit_midreset_stall", 32'(req_stall), 32'd1);

        next_cycle();
        reset = 1'b0;
        div_delay = 3;
        set_req(1'b1, 2'd1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        #1;
        check("lit_post_reset_pending", pending, 32'h0);
        check("lit_post_reset_busy", 32'(fpu_busy), 32'd0);
        check("lit_post_reset_stall", 32'(req_stall), 32'd0);

        next_cycle();
        set_req(1'b1, 2'd2, 5'd21, 5'd22, 1'b1, 5'd23, 1'b1);
        #1;
        check("lit_slot_conflict", 32'(req_stall), 32'd1);

        next_cycle();
        #1;
        check("lit_mul_next_slot", 32'(start_mul), 32'd1);

        next_cycle();
        set_req(1'b1, 2'd2, 5'd24, 5'd1, 1'b1, 5'd25, 1'b0);
        #1;
        check("lit_raw_stall", 32'(req_stall), 32'd1);

        repeat (1500) begin
            next_cycle();
            rand_req();
        end

        // Divider waiting while the CPU streams i2f
        div_delay = 1;
        got_div = 1'b0;
        for (int i = 0; i < 80 && !got_div; i++) begin
            next_cycle();
            set_req(1'b1, 2'd3, 5'd30, 5'd0, 1'b0, 5'd0, 1'b0);
            #1;
            got_div = start_div;
        end
        if (!got_div) check("fdiv_accept_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            set_req(1'b1, 2'd0, 5'(16 + (i % 12)), 5'd0, 1'b0, 5'd0, 1'b0);
        end

        div_delay = 4;
        repeat (1500) begin
            next_cycle();
            reset = ($urandom_range(0, 99) == 0);
            div_delay = int'($urandom_range(1, 8));
            rand_req();
        end
        next_cycle();
        reset = 1'b0;
        set_req(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        next_cycle();
        @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
